// File: rtl/feed_pkg.sv
// Shared widths, task/result layouts and a small wrap-around helper for the
// multi-lane solver feeder.
package feed_pkg;
  localparam int IN_W       = 18;
  localparam int OUT_W      = 24;
  localparam int TASK_BEATS = 8;
  localparam int RES_BEATS  = 4;
  localparam int TASK_W     = 144;
  localparam int RES_W      = 80;

  typedef struct packed {
    logic [15:0] taskid;
    logic [63:0] opponent;
    logic [63:0] player;
  } task_t;

  typedef struct packed {
    logic [63:0] result;
    logic [15:0] taskid;
  } result_t;

  // Round-robin pointer increment, wrapping at n-1.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is dropped even
// if a pop happens in the same cycle.
module result_fifo #(
  parameter int W     = 80,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full     = (r_count == (AW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/feed_multi.sv
// Multi-lane solver feeder: assembles 18-bit beats into tasks, deals them
// round-robin to lanes, collects results and serialises them as 24-bit beats.
module feed_multi
  import feed_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ORDERED   = 1,
  parameter int OUT_DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TASK_W-1:0]          lane_task_data,
  output logic [NUM_LANES-1:0]       lane_task_valid,
  input  logic [NUM_LANES-1:0]       lane_task_ready,
  input  logic [NUM_LANES*RES_W-1:0] lane_res_data,
  input  logic [NUM_LANES-1:0]       lane_res_valid,
  output logic [NUM_LANES-1:0]       lane_res_ready,
  output logic [15:0]                in_flight,
  output logic                       busy
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic [2:0]        r_cnt;
  logic [TASK_W-1:0] r_asm;
  task_t             r_disp;
  logic              r_disp_valid;
  logic [LW-1:0]     r_rr_d;
  logic [LW-1:0]     r_rr_c;
  logic [1:0]        r_sbeat;
  logic [15:0]       r_in_flight;

  logic              w_in_fire;
  logic              w_load;
  logic              w_disp_fire;
  logic              w_res_fire;
  logic              w_out_fire;
  logic              w_pop;
  logic [LW-1:0]     w_grant;
  logic              w_grant_valid;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [RES_W-1:0]  w_push_data;
  logic [RES_W-1:0]  w_head;
  logic [95:0]       w_wide;

  // Valid/ready: a transfer happens on a rising clock when both are high;
  // valid and data are held until ready, and valid never waits on ready.
  assign w_disp_fire = !reset && r_disp_valid && lane_task_ready[r_rr_d];
  assign in_ready    = !reset && !(r_cnt == 3'd7 && r_disp_valid && !w_disp_fire);
  assign w_in_fire   = in_valid && in_ready;
  assign w_load      = w_in_fire && (r_cnt == 3'd7);

  always_comb begin
    lane_task_valid = '0;
    if (!reset && r_disp_valid) lane_task_valid[r_rr_d] = 1'b1;
  end
  assign lane_task_data = r_disp;

  // Ordered mode only listens to the lane that owns the next result; the
  // unordered mode grants the first valid lane at or after the pointer.
  always_comb begin
    w_grant       = r_rr_c;
    w_grant_valid = 1'b0;
    if (ORDERED != 0) begin
      w_grant_valid = lane_res_valid[r_rr_c];
    end else begin
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
        if (lane_res_valid[(32'(r_rr_c) + k) % NUM_LANES]) begin
          w_grant       = LW'((32'(r_rr_c) + k) % NUM_LANES);
          w_grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    lane_res_ready = '0;
    if (!reset && !w_full && (ORDERED != 0 || w_grant_valid))
      lane_res_ready[w_grant] = 1'b1;
  end

  assign w_res_fire  = !reset && !w_full && w_grant_valid;
  assign w_push_data = lane_res_data[RES_W*32'(w_grant) +: RES_W];

  result_fifo #(
    .W     (RES_W),
    .DEPTH (OUT_DEPTH)
  ) u_result_fifo (
    .clk       (clock),
    .rst       (reset),
    .push      (w_res_fire),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign out_valid  = !reset && !w_empty;
  assign w_out_fire = out_valid && out_ready;
  assign w_pop      = w_out_fire && (r_sbeat == 2'd3);
  assign w_wide     = {16'h0, w_head};
  assign out_data   = out_valid ? w_wide[OUT_W*32'(r_sbeat) +: OUT_W] : '0;

  assign in_flight = reset ? 16'h0 : r_in_flight;
  assign busy      = !reset && (r_cnt != 3'd0 || r_disp_valid ||
                                r_in_flight != 16'h0 || !w_empty);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= '0;
      r_asm        <= '0;
      r_disp       <= '0;
      r_disp_valid <= 1'b0;
      r_rr_d       <= '0;
      r_rr_c       <= '0;
      r_sbeat      <= '0;
      r_in_flight  <= '0;
    end else begin
      if (w_in_fire) begin
        r_asm[IN_W*32'(r_cnt) +: IN_W] <= in_data;
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_disp_fire) begin
        r_disp_valid <= 1'b0;
        r_rr_d       <= LW'(wrap_inc(32'(r_rr_d), NUM_LANES));
      end
      // The last beat goes straight into the dispatch register.
      if (w_load) begin
        r_disp       <= task_t'({in_data, r_asm[TASK_W-IN_W-1:0]});
        r_disp_valid <= 1'b1;
      end
      if (w_res_fire) r_rr_c <= LW'(wrap_inc(32'(w_grant), NUM_LANES));
      if (w_out_fire) r_sbeat <= r_sbeat + 2'd1;
      case ({w_disp_fire, w_res_fire})
        2'b10:   r_in_flight <= r_in_flight + 16'd1;
        2'b01:   if (r_in_flight != 16'h0) r_in_flight <= r_in_flight - 16'd1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end
endmodule

// File: tb/tb_feed_multi.sv
// Directed bench for feed_multi: an ordered and an unordered instance share
// the task side; each has its own result lanes, host output and scoreboard.
module tb_feed_multi;
  import feed_pkg::*;

  localparam int NL = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic [NL-1:0]     ltr = '0;

  logic              in_ready [2];
  logic [OUT_W-1:0]  out_data [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic [TASK_W-1:0] ltd [2];
  logic [NL-1:0]     ltv [2];
  logic [NL*RES_W-1:0] lrd [2];
  logic [NL-1:0]     lrv [2];
  logic [NL-1:0]     lrr [2];
  logic [15:0]       in_flight [2];
  logic              busy [2];

  int total = 0;
  int bad   = 0;

  logic [TASK_W-1:0] task_q [$];
  logic [OUT_W-1:0]  exp_q0 [$];
  logic [OUT_W-1:0]  exp_q1 [$];
  int                fire_log [$];
  logic [NL-1:0]     acc [2];
  logic [15:0]       mdl_if [2];
  logic              prev_hold [2];
  logic [OUT_W-1:0]  prev_data [2];
  int                exp_lane = 0;

  always #5 clk = ~clk;

  feed_multi #(.NUM_LANES(NL), .ORDERED(1), .OUT_DEPTH(16)) dut_ord (
    .clock(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .lane_task_data(ltd[0]), .lane_task_valid(ltv[0]),
    .lane_task_ready(ltr), .lane_res_data(lrd[0]), .lane_res_valid(lrv[0]),
    .lane_res_ready(lrr[0]), .in_flight(in_flight[0]), .busy(busy[0]));

  feed_multi #(.NUM_LANES(NL), .ORDERED(0), .OUT_DEPTH(16)) dut_arr (
    .clock(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .lane_task_data(ltd[1]), .lane_task_valid(ltv[1]),
    .lane_task_ready(ltr), .lane_res_data(lrd[1]), .lane_res_valid(lrv[1]),
    .lane_res_ready(lrr[1]), .in_flight(in_flight[1]), .busy(busy[1]));

  task automatic check(input string name, input logic [TASK_W-1:0] act,
                       input logic [TASK_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Per-cycle compare process: reset values, in_flight model, output
  // scoreboard, hold stability and dispatch order.
  always @(negedge clk) begin
    logic df, rf, have;
    logic [OUT_W-1:0] e;
    for (int d = 0; d < 2; d++) begin
      acc[d] = lrv[d] & lrr[d];
      df = |(ltv[d] & ltr);
      rf = |acc[d];
      if (rst) begin
        mdl_if[d] = '0;
        prev_hold[d] = 1'b0;
        check($sformatf("reset_outputs%0d", d),
              TASK_W'({in_ready[d], out_valid[d], ltv[d], lrr[d], out_data[d],
                       in_flight[d], busy[d]}), '0);
      end else begin
        check($sformatf("in_flight%0d", d), TASK_W'(in_flight[d]), TASK_W'(mdl_if[d]));
        if (df && !rf) mdl_if[d] = mdl_if[d] + 16'd1;
        else if (rf && !df && mdl_if[d] != 16'd0) mdl_if[d] = mdl_if[d] - 16'd1;
        if (prev_hold[d])
          check($sformatf("out_hold%0d", d), TASK_W'(out_data[d]), TASK_W'(prev_data[d]));
        if (out_valid[d] && out_ready[d]) begin
          have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
          if (!have) begin
            total++;
            bad++;
            $display("FAIL out_extra%0d: got %h expected no beat", d, out_data[d]);
          end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("out_beat%0d", d), TASK_W'(out_data[d]), TASK_W'(e));
          end
        end
        prev_hold[d] = out_valid[d] && !out_ready[d];
        prev_data[d] = out_data[d];
      end
    end
    if (rst) begin
      exp_lane = 0;
    end else if (ltv[0] != '0) begin
      check("disp_lane", TASK_W'(ltv[0]), TASK_W'(NL'(1) << exp_lane));
      if (|(ltv[0] & ltr)) begin
        fire_log.push_back($clog2(ltv[0]));
        if (task_q.size() == 0) timeout("disp_unexpected");
        else check("disp_data", ltd[0], task_q.pop_front());
        exp_lane = (exp_lane + 1) % NL;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) lrv[d] = lrv[d] & ~acc[d];
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++) lrv[d] = '0;
    step();
    step();
    task_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    fire_log.delete();
    rst = 1'b0;
    step();
  endtask

  task automatic send_task(input logic [TASK_W-1:0] t);
    int n;
    for (int k = 0; k < TASK_BEATS; k++) begin
      in_valid = 1'b1;
      in_data  = t[IN_W*k +: IN_W];
      n = 0;
      while (!in_ready[0] && n < 200) begin
        step();
        n++;
      end
      if (n >= 200) timeout("in_ready_wait");
      step();
    end
    in_valid = 1'b0;
    task_q.push_back(t);
  endtask

  task automatic push_res(input int d, input logic [RES_W-1:0] r);
    logic [95:0] w;
    w = {16'h0, r};
    for (int k = 0; k < RES_BEATS; k++) begin
      if (d == 0) exp_q0.push_back(w[OUT_W*k +: OUT_W]);
      else        exp_q1.push_back(w[OUT_W*k +: OUT_W]);
    end
  endtask

  task automatic push_lit(input logic [OUT_W-1:0] b);
    exp_q0.push_back(b);
    exp_q1.push_back(b);
  endtask

  task automatic offer(input int lane, input logic [RES_W-1:0] r);
    for (int d = 0; d < 2; d++) begin
      lrv[d][lane] = 1'b1;
      lrd[d][RES_W*lane +: RES_W] = r;
    end
  endtask

  task automatic wait_disp();
    int n = 0;
    while (task_q.size() != 0 && n < 300) begin step(); n++; end
    if (n >= 300) timeout("dispatch_wait");
  endtask

  task automatic wait_res_clear();
    int n = 0;
    while ((lrv[0] | lrv[1]) != '0 && n < 300) begin step(); n++; end
    if (n >= 300) timeout("lane_accept_wait");
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 2000) begin step(); n++; end
    if (n >= 2000) timeout("drain_wait");
  endtask

  initial begin
    logic [TASK_W-1:0] t;
    logic [RES_W-1:0]  r1, r2, r3, r;
    int exp_log [5];
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      lrv[d] = '0;
      lrd[d] = '0;
    end
    do_reset();

    // First task: beats 1..8, only lane 0 ready.
    ltr = 4'b0001;
    for (int k = 0; k < TASK_BEATS; k++) t[IN_W*k +: IN_W] = IN_W'(k + 1);
    send_task(t);
    check("t1_lane_valid", TASK_W'(ltv[0]), TASK_W'(4'b0001));
    check("t1_data_lo", TASK_W'(ltd[0][17:0]), TASK_W'(18'd1));
    check("t1_data_hi", TASK_W'(ltd[0][143:126]), TASK_W'(18'd8));
    step();
    check("t1_in_flight", TASK_W'(in_flight[0]), TASK_W'(16'd1));
    check("t1_busy", TASK_W'(busy[0]), TASK_W'(1'b1));

    // Round-robin dispatch of five tasks with all lanes ready.
    do_reset();
    ltr = 4'b1111;
    for (int i = 0; i < 5; i++)
      send_task({16'(i + 100), $urandom, $urandom, $urandom, $urandom});
    wait_disp();
    exp_log = '{0, 1, 2, 3, 0};
    check("rr_count", TASK_W'(fire_log.size()), TASK_W'(5));
    for (int i = 0; i < 5 && i < fire_log.size(); i++)
      check($sformatf("rr_lane%0d", i), TASK_W'(fire_log[i]), TASK_W'(exp_log[i]));
    check("rr_in_flight", TASK_W'(in_flight[0]), TASK_W'(16'd5));

    // Out-of-order lane returns: ordered vs arrival-order collection.
    do_reset();
    r1 = {64'h1111_2222_3333_4444, 16'd1};
    r2 = {64'h5555_6666_7777_8888, 16'd2};
    r3 = {64'h9999_AAAA_BBBB_CCCC, 16'd3};
    for (int i = 1; i <= 3; i++) send_task({16'(i), $urandom, $urandom, $urandom, $urandom});
    wait_disp();
    push_res(0, r1); push_res(0, r2); push_res(0, r3);
    push_res(1, r2); push_res(1, r3); push_res(1, r1);
    offer(1, r2);
    #1;
    check("ord_ready_first", TASK_W'(lrr[0]), TASK_W'(4'b0001));
    check("arr_ready_first", TASK_W'(lrr[1]), TASK_W'(4'b0010));
    step();
    check("arr_out_latency", TASK_W'(out_valid[1]), TASK_W'(1'b1));
    check("ord_out_idle", TASK_W'(out_valid[0]), TASK_W'(1'b0));
    step();
    check("ord_lane1_blocked", TASK_W'(lrr[0]), TASK_W'(4'b0001));
    offer(0, r1);
    offer(2, r3);
    #1;
    check("ord_ready_lane0", TASK_W'(lrr[0]), TASK_W'(4'b0001));
    check("arr_ready_lane2", TASK_W'(lrr[1]), TASK_W'(4'b0100));
    step();
    check("ord_ready_lane1", TASK_W'(lrr[0]), TASK_W'(4'b0010));
    check("arr_ready_wrap", TASK_W'(lrr[1]), TASK_W'(4'b0001));
    wait_res_clear();
    wait_drain();

    // Serialiser beats under host back-pressure.
    do_reset();
    send_task({16'hBEEF, $urandom, $urandom, $urandom, $urandom});
    wait_disp();
    push_lit(24'hEFBEEF);
    push_lit(24'h89ABCD);
    push_lit(24'h234567);
    push_lit(24'h000001);
    offer(0, {64'h0123456789ABCDEF, 16'hBEEF});
    for (int i = 0; i < 24; i++) begin
      out_ready[0] = (i % 2) == 1;
      out_ready[1] = (i % 3) == 0;
      step();
    end
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    wait_drain();

    // Fill the result buffer with the host stalled, then drain it.
    do_reset();
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    for (int n = 0; n < 16; n++) send_task({16'(n), $urandom, $urandom, $urandom, $urandom});
    wait_disp();
    for (int n = 0; n < 16; n++) begin
      r = {{$urandom, $urandom}, 16'(n + 16'h40)};
      push_res(0, r);
      push_res(1, r);
      offer(n % NL, r);
      wait_res_clear();
    end
    step();
    check("full_lane_ready", TASK_W'(lrr[0]), TASK_W'(4'b0000));
    check("full_busy_ord", TASK_W'(busy[0]), TASK_W'(1'b1));
    check("full_busy_arr", TASK_W'(busy[1]), TASK_W'(1'b1));
    check("full_in_flight", TASK_W'(in_flight[0]), TASK_W'(16'd0));
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    wait_drain();
    step();
    check("drained_busy", TASK_W'(busy[0]), TASK_W'(1'b0));

    // Reset in the middle of a partial task with one task in flight.
    send_task({16'h77, $urandom, $urandom, $urandom, $urandom});
    wait_disp();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = IN_W'(k + 9);
      step();
    end
    in_valid = 1'b0;
    check("pre_reset_busy", TASK_W'(busy[0]), TASK_W'(1'b1));
    check("pre_reset_in_flight", TASK_W'(in_flight[0]), TASK_W'(16'd1));
    rst = 1'b1;
    #1;
    check("mid_reset_in_ready", TASK_W'(in_ready[0]), TASK_W'(1'b0));
    check("mid_reset_busy", TASK_W'(busy[0]), TASK_W'(1'b0));
    check("mid_reset_in_flight", TASK_W'(in_flight[0]), TASK_W'(16'd0));
    step();
    step();
    rst = 1'b0;
    step();
    check("post_reset_busy", TASK_W'(busy[0]), TASK_W'(1'b0));
    check("post_reset_in_ready", TASK_W'(in_ready[0]), TASK_W'(1'b1));
    check("post_reset_in_flight", TASK_W'(in_flight[0]), TASK_W'(16'd0));

    check("left_ord", TASK_W'(exp_q0.size()), '0);
    check("left_arr", TASK_W'(exp_q1.size()), '0);
    check("left_tasks", TASK_W'(task_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
